// File: rtl/z80_irq_pkg.sv
// Shared defaults and types for the Z80 vblank interrupt controller.
package z80_irq_pkg;

    localparam logic [15:0] IRQ_EN_ADR_DEF = 16'hA800;
    localparam logic [15:0] WDOG_ADR_DEF   = 16'hA900;
    localparam int unsigned HOLD_CYC_DEF   = 512;
    localparam int unsigned WD_FRAMES_DEF  = 8;
    localparam int unsigned WD_PULSE_CYC   = 16;

    typedef enum logic {
        StIdle,
        StAssert
    } irq_state_e;

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector; stays blind for the first clock after reset
// so a level already high at reset release is not taken as an edge.
module rise_det (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic rise
);

    logic prev_q;
    logic armed_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= sig;
            armed_q <= 1'b1;
        end
    end

    assign rise = sig & ~prev_q & armed_q;

endmodule

// File: rtl/z80_irq_ctrl.sv
// Vblank interrupt generator with CPU-writable enable latch.
// Optional vblank watchdog compiled in with Z80_IRQ_CTRL_WATCHDOG_EN.
module z80_irq_ctrl
    import z80_irq_pkg::*;
#(
    parameter logic [15:0] IRQ_EN_ADR = IRQ_EN_ADR_DEF,
    parameter logic [15:0] WDOG_ADR   = WDOG_ADR_DEF,
    parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF,
    parameter int unsigned WD_FRAMES  = WD_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vblank,
    input  logic [15:0] adr,
    input  logic [7:0]  din,
    input  logic        wr,
    output logic        intreq,
    output logic        irq_en,
    output logic        wd_reset
);

    localparam int unsigned HoldW = $clog2(HOLD_CYC);
    localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_CYC - 1);

    logic wstb;
    logic vb_rise;

    rise_det u_wr_det (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (wr),
        .rise    (wstb)
    );

    rise_det u_vb_det (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (vblank),
        .rise    (vb_rise)
    );

    logic en_wr;
    logic dis_wr;

    assign en_wr  = wstb && (adr == IRQ_EN_ADR);
    assign dis_wr = en_wr && !din[0];

    logic irq_en_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
        end else if (en_wr) begin
            irq_en_q <= din[0];
        end
    end

    assign irq_en = irq_en_q;

    irq_state_e       state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // irq_en_q is the pre-write value, so an enabling write in the rise cycle
    // cannot assert; a disabling write in that cycle blocks explicitly.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (vb_rise && irq_en_q && !dis_wr) begin
                    state_d = StAssert;
                    hold_d  = HoldInit;
                end
            end
            StAssert: begin
                if (dis_wr || (hold_q == '0)) begin
                    state_d = StIdle;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                hold_d  = '0;
            end
        endcase
    end

    assign intreq = (state_q == StAssert);

    logic unused_din;
    assign unused_din = ^din[7:1];

`ifdef Z80_IRQ_CTRL_WATCHDOG_EN
    localparam int unsigned WdW  = $clog2(WD_FRAMES + 1);
    localparam int unsigned TmrW = $clog2(WD_PULSE_CYC);

    logic            kick;
    logic [WdW-1:0]  wd_cnt_q, wd_cnt_d;
    logic [TmrW-1:0] wd_tmr_q, wd_tmr_d;
    logic            wd_act_q, wd_act_d;

    assign kick = wstb && (adr == WDOG_ADR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
            wd_tmr_q <= '0;
            wd_act_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_tmr_q <= wd_tmr_d;
            wd_act_q <= wd_act_d;
        end
    end

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        wd_tmr_d = wd_tmr_q;
        wd_act_d = wd_act_q;
        if (wd_act_q) begin
            if (wd_tmr_q == '0) begin
                wd_act_d = 1'b0;
            end else begin
                wd_tmr_d = wd_tmr_q - TmrW'(1);
            end
        end
        // A kick wins over a vblank edge in the same cycle.
        if (kick) begin
            wd_cnt_d = '0;
        end else if (vb_rise) begin
            if (wd_cnt_q == WdW'(WD_FRAMES - 1)) begin
                wd_cnt_d = '0;
                wd_act_d = 1'b1;
                wd_tmr_d = TmrW'(WD_PULSE_CYC - 1);
            end else begin
                wd_cnt_d = wd_cnt_q + WdW'(1);
            end
        end
    end

    assign wd_reset = wd_act_q;
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_ADR ^ (WD_FRAMES == 0);
    assign wd_reset    = 1'b0;
`endif

endmodule

// File: tb/tb_z80_irq_ctrl.sv
// Self-checking bench for z80_irq_ctrl: vector table, corner sequences and
// randomized traffic against an event-timestamp reference model.
module tb_z80_irq_ctrl;

    localparam int HOLD = 512;
    localparam int WDF  = 8;
`ifdef Z80_IRQ_CTRL_WATCHDOG_EN
    localparam bit WdOn = 1'b1;
`else
    localparam bit WdOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vblank = 1'b0;
    logic [15:0] adr = '0;
    logic [7:0]  din = '0;
    logic        wr = 1'b0;
    logic        intreq;
    logic        irq_en;
    logic        wd_reset;

    always #5 clk = ~clk;

    z80_irq_ctrl #(
        .IRQ_EN_ADR (16'hA800),
        .WDOG_ADR   (16'hA900),
        .HOLD_CYC   (HOLD),
        .WD_FRAMES  (WDF)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .vblank   (vblank),
        .adr      (adr),
        .din      (din),
        .wr       (wr),
        .intreq   (intreq),
        .irq_en   (irq_en),
        .wd_reset (wd_reset)
    );

    int tests = 0;
    int fails = 0;
    int wd_hi = 0;

    // Reference model: intervals [s,e) in cycle-index time where outputs are high.
    int t, irq_s, irq_e, wd_s, wd_e, wd_cnt;
    bit m_en, m_pwr, m_pvb, m_arm;

    function automatic void model_reset();
        t = 0; irq_s = 0; irq_e = 0; wd_s = 0; wd_e = 0; wd_cnt = 0;
        m_en = 0; m_pwr = 0; m_pvb = 0; m_arm = 0;
    endfunction

    function automatic void model_edge();
        bit ws, vr, en_w, dis, kick, high_now;
        ws       = m_arm && wr && !m_pwr;
        vr       = m_arm && vblank && !m_pvb;
        en_w     = ws && (adr == 16'hA800);
        dis      = en_w && !din[0];
        kick     = ws && (adr == 16'hA900);
        high_now = (t >= irq_s) && (t < irq_e);
        if (high_now && dis) begin
            irq_e = t + 1;
        end else if (!high_now && vr && m_en && !dis) begin
            irq_s = t + 1;
            irq_e = t + 1 + HOLD;
        end
        if (en_w) m_en = din[0];
        if (kick) begin
            wd_cnt = 0;
        end else if (vr) begin
            wd_cnt++;
            if (wd_cnt == WDF) begin
                wd_cnt = 0;
                wd_s   = t + 1;
                wd_e   = t + 17;
            end
        end
        m_pwr = wr;
        m_pvb = vblank;
        m_arm = 1;
        t++;
    endfunction

    function automatic logic exp_irq();
        return (t >= irq_s) && (t < irq_e);
    endfunction

    function automatic logic exp_wd();
        return WdOn && (t >= wd_s) && (t < wd_e);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0d: got %0b expected %0b", name, t, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_intreq", intreq, exp_irq());
        check("model_irq_en", irq_en, m_en);
        check("model_wd_reset", wd_reset, exp_wd());
        if (wd_reset === 1'b1) wd_hi++;
    endtask

    // Asserts reset mid-cycle, checks outputs drop at once, releases at negedge.
    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        check("rst_intreq", intreq, 1'b0);
        check("rst_irq_en", irq_en, 1'b0);
        check("rst_wd_reset", wd_reset, 1'b0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wr_cycle(input logic [15:0] a, input logic [7:0] d);
        adr = a; din = d; wr = 1'b1;
        step();
        wr = 1'b0;
        step();
    endtask

    task automatic vb_pulse();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        step();
        step();
    endtask

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
        logic        vb;
        logic        e_irq;
        logic        e_en;
    } vec_t;

    vec_t tbl[23];

    initial begin
        int hi;
        tbl[0]  = '{1'b1, 16'hA800, 8'h01, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 16'hA800, 8'h01, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 16'hA800, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 16'hA800, 8'h01, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 16'hA800, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 16'hA800, 8'h01, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 16'hA800, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 16'hA800, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 16'hA800, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 16'hA800, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 16'h1234, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[19] = '{1'b1, 16'hA900, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[20] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[21] = '{1'b1, 16'hA800, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};

        model_reset();
        #3;
        apply_reset();
        step();

        foreach (tbl[i]) begin
            wr = tbl[i].w; adr = tbl[i].a; din = tbl[i].d; vblank = tbl[i].vb;
            step();
            check($sformatf("tbl%0d_intreq", i), intreq, tbl[i].e_irq);
            check($sformatf("tbl%0d_irq_en", i), irq_en, tbl[i].e_en);
        end

        // Full-length hold.
        wr_cycle(16'hA800, 8'h01);
        vblank = 1'b1;
        step();
        check("hold_rise_next", intreq, 1'b1);
        hi = 1;
        vblank = 1'b0;
        for (int i = 0; i < 600 && intreq === 1'b1; i++) begin
            step();
            if (intreq === 1'b1) hi++;
        end
        check_int("hold_len", hi, HOLD);

        // Disable at cycle 100 of the hold.
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        for (int i = 0; i < 99; i++) step();
        check("pre_dis_intreq", intreq, 1'b1);
        adr = 16'hA800; din = 8'h00; wr = 1'b1;
        step();
        check("dis_intreq", intreq, 1'b0);
        check("dis_irq_en", irq_en, 1'b0);
        wr = 1'b0;
        step();

        // Disabled: vblank rise does nothing.
        vb_pulse();
        check("disabled_no_irq", intreq, 1'b0);

        // Watchdog: 8 edges unkicked, then kicks every 7 edges.
        #2;
        apply_reset();
        step();
        wd_hi = 0;
        for (int k = 0; k < WDF; k++) vb_pulse();
        for (int i = 0; i < 24; i++) step();
        check_int("wd_pulse_len", wd_hi, WdOn ? 16 : 0);
        wd_hi = 0;
        for (int k = 0; k < 28; k++) begin
            vb_pulse();
            if (k % 7 == 6) wr_cycle(16'hA900, 8'($urandom));
        end
        check_int("wd_kicked_quiet", wd_hi, 0);

        // Async reset mid-assert, release with vblank high.
        wr_cycle(16'hA800, 8'h01);
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_intreq", intreq, 1'b1);
        #2;
        vblank = 1'b1;
        apply_reset();
        for (int i = 0; i < 3; i++) step();
        wr_cycle(16'hA800, 8'h01);
        check("held_vb_no_irq", intreq, 1'b0);
        vblank = 1'b0;
        step();
        vblank = 1'b1;
        step();
        check("rise_after_rst", intreq, 1'b1);

        // Randomized traffic.
        #2;
        apply_reset();
        for (int i = 0; i < 5000; i++) begin
            int sel;
            sel = $urandom_range(0, 7);
            wr  = ($urandom_range(0, 3) == 0);
            adr = (sel < 3) ? 16'hA800 : (sel < 5) ? 16'hA900 : 16'($urandom);
            din = 8'($urandom);
            if ($urandom_range(0, 5) == 0) vblank = ~vblank;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/z80_irq_ctrl.md
Z80_IRQ_CTRL -- requirements
Module: z80_irq_ctrl

Interface
REQ-001 SHALL have parameter IRQ_EN_ADR, default 16'hA800, CPU write address of the interrupt-enable latch.
REQ-002 SHALL have parameter WDOG_ADR, default 16'hA900, CPU write address of the watchdog kick.
REQ-003 SHALL have parameter HOLD_CYC, default 512, number of clk cycles intreq stays high if not cleared.
REQ-004 SHALL have parameter WD_FRAMES, default 8, number of vblank edges without a kick before watchdog fires.
REQ-005 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port vblank, input, 1, video vertical-blank level, synchronous to clk.
REQ-008 SHALL have port adr, input, 16, CPU address bus.
REQ-009 SHALL have port din, input, 8, CPU write data.
REQ-010 SHALL have port wr, input, 1, CPU memory write strobe, level, refresh already excluded.
REQ-011 SHALL have port intreq, output, 1, active-high interrupt request to the CPU wrapper.
REQ-012 SHALL have port irq_en, output, 1, current interrupt-enable latch.
REQ-013 SHALL have port wd_reset, output, 1, active-high watchdog reset request.

Function
REQ-014 SHALL detect a CPU write as wr high this cycle and low the previous cycle (wstb); exactly one wstb per write access regardless of strobe length.
REQ-015 SHALL, on wstb with adr==IRQ_EN_ADR, load irq_en from din[0].
REQ-016 SHALL detect a vblank rising edge (vb_rise) as vblank high now, low the previous cycle.
REQ-017 SHALL implement a two-state FSM: IDLE (intreq=0) and ASSERT (intreq=1); intreq is a registered output.
REQ-018 SHALL go IDLE->ASSERT on vb_rise when irq_en=1, loading hold counter with HOLD_CYC-1; intreq rises one cycle after vb_rise.
REQ-019 SHALL go ASSERT->IDLE when the hold counter reaches 0 (intreq high exactly HOLD_CYC cycles), or on wstb to IRQ_EN_ADR with din[0]=0 (intreq low next cycle).
REQ-020 SHALL ignore vb_rise while in ASSERT; the counter is not restarted.
REQ-021 SHALL give priority to a disabling write over a simultaneous vb_rise: no assertion occurs.
REQ-022 SHALL allow an enabling write and a vb_rise in the same cycle to assert nothing; enable takes effect for the next vb_rise.
REQ-023 SHALL size the hold counter as clog2(HOLD_CYC) bits; HOLD_CYC>=2.

Reset
REQ-024 SHALL, while reset_n=0, force intreq=0, irq_en=0, wd_reset=0, FSM=IDLE, all counters and edge registers 0.
REQ-025 SHALL, after reset release mid-vblank, not treat the already-high vblank as an edge.

Configuration
REQ-026 SHALL compile the watchdog only when Z80_IRQ_CTRL_WATCHDOG_EN is defined.
REQ-027 SHALL, with the macro, count vb_rise events, clear the count on wstb to WDOG_ADR (data ignored), and when the count reaches WD_FRAMES pulse wd_reset high for 16 cycles then clear the count.
REQ-028 SHALL give priority to a kick over a simultaneous vb_rise (count becomes 0).
REQ-029 SHALL, without the macro, tie wd_reset to 0 and ignore writes to WDOG_ADR.

Structure
REQ-030 SHALL place default addresses, HOLD_CYC, WD_FRAMES and the FSM state enum in package z80_irq_pkg.
REQ-031 SHALL use one sub-module, rise_det (registered rising-edge detector, async active-low reset), instanced for wr and vblank.

Verification
REQ-032 SHALL cover: write 8'h01 to 16'hA800, vblank rise -> intreq high on next cycle for exactly 512 cycles.
REQ-033 SHALL cover: irq_en=0, vblank rise -> intreq stays 0.
REQ-034 SHALL cover: intreq high, write 8'h00 to 16'hA800 at cycle 100 of hold -> intreq low next cycle, irq_en=0.
REQ-035 SHALL cover: 4-cycle wr strobe to 16'hA800 -> single latch update; write same cycle as vb_rise with din=0 -> no intreq.
REQ-036 SHALL cover: macro defined, 8 vblank edges without kick -> wd_reset high 16 cycles; kick every 7 edges -> wd_reset never asserts.
REQ-037 SHALL cover: reset_n low mid-ASSERT -> intreq 0 immediately (async); release while vblank high -> no assertion until next rise.
